// File: rtl/ccff_stream_loader.sv
// Streams bitstream words MSB-first into a ccff configuration chain, one bit per prog_clk.
// Define CCFF_LOOPBACK_CHECK_EN to prepend an 8'hA5 header and verify it at ccff_tail.
module ccff_stream_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err
);
`ifdef CCFF_LOOPBACK_CHECK_EN
    localparam int HDR_LEN = 8;
`else
    localparam int HDR_LEN = 0;
`endif
    localparam int TOTAL = CHAIN_LEN + HDR_LEN;
    localparam int CNT_W = (TOTAL > 65535) ? 17 : 16;
    localparam int BIT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
    localparam logic [BIT_W-1:0] WORD_W_C = BIT_W'(WORD_W);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    state_t             r_state;
    logic [1:0]         r_rst_sync;
    logic [WORD_W-1:0]  r_word;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   r_shift_cnt;
    logic               r_head;
    logic               r_shift_en;
    logic               r_busy;
    logic               r_done;
    logic               w_rst_n;
    logic               w_hdr_pend;
    logic               w_out_bit;
    logic               w_last_bit;
    logic               w_final_shift;

    // Reset asserts immediately but releases two edges after pReset rises.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) r_rst_sync <= 2'b00;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

`ifdef CCFF_LOOPBACK_CHECK_EN
    localparam logic [CNT_W-1:0] CHAIN_C = CNT_W'(CHAIN_LEN);
    logic [7:0] r_hdr;
    logic [3:0] r_hdr_cnt;
    logic [7:0] r_tail_sr;
    logic       r_err;
    logic [7:0] w_tail_next;
    logic       w_sample;

    assign w_hdr_pend  = (r_hdr_cnt != 4'd0);
    assign w_out_bit   = w_hdr_pend ? r_hdr[7] : r_word[WORD_W-1];
    assign w_last_bit  = w_hdr_pend ? (r_hdr_cnt == 4'd1) : (r_bit_cnt == BIT_W'(1));
    assign w_tail_next = {r_tail_sr[6:0], ccff_tail};
    // r_shift_cnt equals the index of the bit the chain captures on an enabled edge.
    assign w_sample    = r_shift_en && (r_shift_cnt > CHAIN_C) && (r_shift_cnt <= TOTAL_C);
    assign err         = r_err;
`else
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail;
    assign w_hdr_pend    = 1'b0;
    assign w_out_bit     = r_word[WORD_W-1];
    assign w_last_bit    = (r_bit_cnt == BIT_W'(1));
    assign err           = 1'b0;
`endif

    assign w_final_shift = (r_shift_cnt == TOTAL_C - CNT_W'(1));
    // The final word's ready is suppressed so leftover low bits are never fetched past TOTAL.
    assign word_ready    = ((r_state == FETCH) && !w_hdr_pend) ||
                           ((r_state == SHIFT) && w_last_bit && !w_final_shift);
    assign ccff_head     = r_head;
    assign ccff_shift_en = r_shift_en;
    assign busy          = r_busy;
    assign done          = r_done;

    always_ff @(posedge prog_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= IDLE;
            r_word      <= '0;
            r_bit_cnt   <= '0;
            r_shift_cnt <= '0;
            r_head      <= 1'b0;
            r_shift_en  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef CCFF_LOOPBACK_CHECK_EN
            r_hdr       <= 8'h00;
            r_hdr_cnt   <= 4'd0;
            r_tail_sr   <= 8'h00;
            r_err       <= 1'b0;
`endif
        end else begin
`ifdef CCFF_LOOPBACK_CHECK_EN
            if (w_sample) r_tail_sr <= w_tail_next;
`endif
            case (r_state)
                IDLE, DONE: begin
                    r_shift_en <= 1'b0;
                    if (start && !r_busy) begin
                        r_state     <= FETCH;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_shift_cnt <= '0;
                        r_bit_cnt   <= '0;
`ifdef CCFF_LOOPBACK_CHECK_EN
                        r_err       <= 1'b0;
                        r_hdr       <= 8'hA5;
                        r_hdr_cnt   <= 4'd8;
                        r_tail_sr   <= 8'h00;
`endif
                    end else if (r_state == DONE) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
`ifdef CCFF_LOOPBACK_CHECK_EN
                        if (r_shift_en) r_err <= (w_tail_next != 8'hA5);
`endif
                    end
                end
                FETCH: begin
                    r_shift_en <= 1'b0;
                    if (w_hdr_pend) begin
                        r_state <= SHIFT;
                    end else if (word_valid) begin
                        r_word    <= word_data;
                        r_bit_cnt <= WORD_W_C;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_head      <= w_out_bit;
                    r_shift_en  <= 1'b1;
                    r_shift_cnt <= r_shift_cnt + CNT_W'(1);
`ifdef CCFF_LOOPBACK_CHECK_EN
                    if (w_hdr_pend) begin
                        r_hdr     <= r_hdr << 1;
                        r_hdr_cnt <= r_hdr_cnt - 4'd1;
                    end else begin
`else
                    begin
`endif
                        r_word    <= r_word << 1;
                        r_bit_cnt <= r_bit_cnt - BIT_W'(1);
                    end
                    if (w_final_shift) begin
                        r_state <= DONE;
                    end else if (w_last_bit) begin
                        if (word_valid) begin
                            r_word    <= word_data;
                            r_bit_cnt <= WORD_W_C;
                        end else begin
                            r_state <= FETCH;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
